// File: rtl/ins_cache.sv
// rtl/ins_cache.sv - read-only direct-mapped instruction cache, 8 lines x 16 bytes
module ins_cache (
  input  logic         clock,
  input  logic         reset,
  input  logic         read,
  input  logic [9:0]   address,
  output logic [31:0]  instruction,
  output logic         busywait,
  output logic         mem_read,
  output logic [5:0]   mem_address,
  input  logic [127:0] mem_readdata,
  input  logic         mem_busywait
);

  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

  state_t         state_q, state_d;
  logic [7:0]     valid_q, valid_d;
  logic [2:0]     tag_q  [8];
  logic [2:0]     tag_d  [8];
  logic [127:0]   data_q [8];
  logic [127:0]   data_d [8];
  logic [127:0]   line_q, line_d;

  logic [2:0]     addr_tag;
  logic [2:0]     addr_index;
  logic [1:0]     addr_word;
  logic           hit;

  assign addr_tag    = address[9:7];
  assign addr_index  = address[6:4];
  assign addr_word   = address[3:2];
  assign hit         = read && valid_q[addr_index] && (tag_q[addr_index] == addr_tag);
  assign instruction = data_q[addr_index][{addr_word, 5'b00000} +: 32];

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    data_d      = data_q;
    line_d      = line_q;
    mem_read    = 1'b0;
    mem_address = 6'd0;
    busywait    = 1'b0;

    case (state_q)
      IDLE: begin
        busywait = read && !hit;
        if (read && !hit) state_d = MEM_READ;
      end
      MEM_READ: begin
        mem_read    = 1'b1;
        mem_address = {addr_tag, addr_index};
        busywait    = 1'b1;
        if (!mem_busywait) begin
          line_d  = mem_readdata;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        busywait            = 1'b1;
        data_d[addr_index]  = line_q;
        tag_d[addr_index]   = addr_tag;
        valid_d[addr_index] = 1'b1;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset aborts any fill in progress: nothing is installed at that edge.
    if (reset) begin
      state_d  = IDLE;
      valid_d  = '0;
      tag_d    = tag_q;
      data_d   = data_q;
      busywait = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  // Tag, data and the fill buffer carry no reset; valid bits guard them.
  always_ff @(posedge clock) begin
    tag_q  <= tag_d;
    data_q <= data_d;
    line_q <= line_d;
  end

endmodule

// File: tb/tb_ins_cache.sv
// tb/tb_ins_cache.sv - self-checking bench for ins_cache with a behavioural cache model
module tb_ins_cache;

  logic         clock = 1'b0;
  logic         reset;
  logic         read;
  logic [9:0]   address;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  int passed = 0;
  int total  = 0;

  logic [127:0] mem_blk [64];
  int           lat_mem = 0;
  int           cnt_mem = 0;

  bit           ref_valid [8];
  logic [2:0]   ref_tag   [8];
  logic [127:0] ref_blk   [8];

  always #5 clock = ~clock;

  ins_cache dut (
    .clock        (clock),
    .reset        (reset),
    .read         (read),
    .address      (address),
    .instruction  (instruction),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  // Memory holds busywait for lat_mem cycles of mem_read, then presents data.
  assign mem_readdata = mem_blk[mem_address];
  assign mem_busywait = mem_read && (cnt_mem != lat_mem);
  always @(posedge clock) cnt_mem <= mem_read ? cnt_mem + 1 : 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
  endtask

  function automatic logic [31:0] word_of(input logic [127:0] blk, input logic [1:0] w);
    return blk[w*32 +: 32];
  endfunction

  task automatic fetch(input logic [9:0] a, input int lat, input bit drop);
    int         idx, tg, n;
    bit         exp_hit;
    logic [5:0] blk_addr;
    @(negedge clock);
    lat_mem = lat;
    read    = 1'b1;
    address = a;
    #1;
    idx      = a / 16 % 8;
    tg       = a / 128;
    blk_addr = 6'(a / 16);
    exp_hit  = ref_valid[idx] && (ref_tag[idx] == 3'(tg));
    chk("busy_first_cycle", busywait, !exp_hit);
    chk("mem_read_first_cycle", mem_read, 1'b0);
    if (exp_hit) begin
      chk("hit_instr", instruction, word_of(ref_blk[idx], a[3:2]));
    end else begin
      n = 0;
      @(negedge clock); #1;
      while (mem_read && n < 60) begin
        chk("miss_mem_address", mem_address, blk_addr);
        chk("miss_busy", busywait, 1'b1);
        n++;
        if (drop) read = 1'b0;
        @(negedge clock); #1;
      end
      chk("mem_read_cycles", n, lat + 1);
      chk("update_busy", busywait, 1'b1);
      chk("update_mem_address", mem_address, 6'd0);
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = 3'(tg);
      ref_blk[idx]   = mem_blk[blk_addr];
      @(negedge clock); #1;
      chk("fill_busy", busywait, 1'b0);
      chk("fill_mem_read", mem_read, 1'b0);
      if (!drop) chk("fill_instr", instruction, word_of(ref_blk[idx], a[3:2]));
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++)
      mem_blk[i] = {$urandom, $urandom, $urandom, $urandom};
    mem_blk[0][31:0]  = 32'h00060002;
    mem_blk[0][63:32] = 32'h00070005;
    mem_blk[4][31:0]  = 32'h0802000F;
    clear_model();

    reset   = 1'b1;
    read    = 1'b1;
    address = 10'h000;
    @(negedge clock); #1;
    chk("reset_busy", busywait, 1'b0);
    @(negedge clock); #1;
    chk("reset_mem_read", mem_read, 1'b0);
    chk("reset_mem_address", mem_address, 6'd0);
    reset = 1'b0;
    read  = 1'b0;

    // Cold miss, same-line hit, second index, line 0 still valid
    fetch(10'h000, 2, 1'b0);
    chk("cold_word0", instruction, 32'h00060002);
    fetch(10'h004, 0, 1'b0);
    chk("same_line_word1", instruction, 32'h00070005);
    chk("same_line_busy", busywait, 1'b0);
    fetch(10'h040, 1, 1'b0);
    chk("index4_word0", instruction, 32'h0802000F);
    fetch(10'h000, 0, 1'b0);
    chk("line0_still_hits", busywait, 1'b0);

    // Conflict eviction both ways
    fetch(10'h080, 0, 1'b0);
    fetch(10'h000, 1, 1'b0);

    // Reset in the middle of a fill
    @(negedge clock);
    lat_mem = 6;
    read    = 1'b1;
    address = 10'h080;
    @(negedge clock); #1;
    chk("abort_in_mem_read", mem_read, 1'b1);
    reset = 1'b1;
    #1;
    chk("abort_reset_busy", busywait, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    read  = 1'b0;
    #1;
    chk("abort_mem_read_low", mem_read, 1'b0);
    chk("abort_busy_low", busywait, 1'b0);
    clear_model();
    fetch(10'h000, 0, 1'b0);

    // Back-to-back hits across the whole line
    fetch(10'h000, 0, 1'b0);
    fetch(10'h004, 0, 1'b0);
    fetch(10'h008, 0, 1'b0);
    fetch(10'h00C, 0, 1'b0);

    // Read dropped during the fill still installs the line
    fetch(10'h0D0, 2, 1'b1);
    fetch(10'h0D4, 0, 1'b0);

    for (int k = 0; k < 60; k++) begin
      logic [9:0] ra;
      ra = {3'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3))};
      fetch(ra, $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
    end

    @(negedge clock);
    read = 1'b0;
    #1;
    chk("idle_no_read_busy", busywait, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
